sseg_scan_driver: RTL
=====================

Name: sseg_scan_driver

Overview:
Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display bank. It is the generalised successor to the single-digit hex decoder. It scans one digit per slot and adds per-digit decimal points, blanking, leading-zero suppression and tear-free double-buffered updates. It sits between the CPU's output/debug registers and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
PRESCALE, 50000, clock cycles per digit slot (>=2); 50000 at 100 MHz gives a 2 kHz digit rate
SEG_ACTIVE_LOW, 1, 1 drives segments and dp active-low, 0 drives them active-high
AN_ACTIVE_LOW, 1, 1 drives anode selects active-low, 0 drives them active-high

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
load  input  1  one-cycle strobe; captures hex_in, dp_in and blank_in into the shadow buffer
hex_in  input  4*DIGITS  nibble i = digit i; digit 0 is least significant (rightmost)
dp_in  input  DIGITS  decimal point request per digit
blank_in  input  DIGITS  force digit i dark
lz_en  input  1  leading-zero suppression enable (level)
an  output  DIGITS  anode selects, one-hot active
sseg  output  7  segments g..a (bit6=g, bit0=a)
dp  output  1  decimal point segment
frame_tick  output  1  one-cycle pulse per completed scan

Behaviour:
- Reset (asynchronous, active-high): all state clears.
  - an all inactive; sseg and dp off, respecting the polarity parameters.
  - frame_tick=0; prescaler=0; digit index idx=0.
  - Shadow and active buffers: hex=0, dp=0, blank=all ones, so the display is dark until the first load.
- Prescaler: counts 0..PRESCALE-1 and wraps. A slot tick occurs in the cycle where prescaler==PRESCALE-1.
- On a slot tick, idx advances by 1 and wraps from DIGITS-1 to 0.
- frame_tick=1 for exactly the cycle in which idx wraps DIGITS-1 -> 0 (registered alongside idx).
- load:
  - Captures all inputs into the shadow buffer on that edge.
  - Shadow copies to the active buffer only on a wrap edge, so a frame never mixes old and new data.
  - If load and a wrap coincide on the same edge, the new inputs go straight to active, and the shadow is also updated.
  - Multiple loads within one frame: the last one wins.
- Outputs are registered from the post-edge idx and active buffer. an, sseg and dp change on the edge after idx changes (1-cycle latency). They never glitch mid-slot.
- Exactly one an bit is active in every cycle after the first post-reset edge.
- Segment decode, before polarity: standard hex glyphs.
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - c=1011000, d=1011110, E=1111001, F=1110001
- Blanking: a digit is dark (all 7 segments off) if either condition holds:
  - its active blank bit is set, or
  - it is leading-zero suppressed.
- Leading-zero suppression (lz_en=1, evaluated combinationally on the active buffer):
  - Scanning from digit DIGITS-1 downward, a digit is suppressed while its nibble==0, its dp==0 and every higher digit is suppressed.
  - Digit 0 is never suppressed.
  - lz_en takes effect on the next digit slot without a load.
- dp output = active dp bit of the current digit. It is independent of blank/suppression, except that an explicit blank bit also clears dp.
- Reset mid-scan: immediate return to reset state; the next load is required to show data.

Decomposition:
- Shared package: SEG_OFF/SEG_ON polarity helpers and the 16-entry glyph constant table (7-bit, active-high form).
- One sub-module, seg_decode: combinational nibble -> 7-bit active-high glyph.
- The scan driver applies blanking and polarity itself.

Test Plan:
All scenarios use DIGITS=4, PRESCALE=4 unless stated otherwise.
- Reset, then idle 40 cycles -> an cycles 1110,1101,1011,0111 every 4 cycles; sseg=1111111 throughout (dark); frame_tick pulses every 16 cycles.
- load hex_in=16'h12AF, dp_in=4'b0100, blank_in=0, lz_en=0 -> after next wrap:
  - digit0 sseg=~1110001, digit1 sseg=~1110111, digit2 sseg=~1011011 with dp=0, digit3 sseg=~0000110.
  - Previous frame content unchanged until the wrap.
- load 16'h0050 with lz_en=1 -> digits 3 and 2 dark, digit1 shows 5, digit0 shows 0.
- Same data, then lz_en=1 with dp_in=4'b1000 -> digit3 shows 0 with dp lit.
- load 16'h0000 with lz_en=1 -> only digit0 lit, showing 0.
- load asserted on the exact wrap edge -> new data visible in that same frame's digit0. A second load mid-frame with 16'hFFFF is not visible until the following wrap.
- Assert reset while an=1011 -> an=1111, sseg=1111111 asynchronously. After release, the display stays dark until a load and a wrap.
- Parameter sweep:
  - DIGITS=8, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0 -> one-hot active-high an over 8 slots; glyphs appear uninverted.

Source files
------------

// File: rtl/sseg_scan_driver_pkg.sv
// Shared glyph table and output-polarity helpers for the seven-segment scan driver.
package sseg_scan_driver_pkg;

   // Active-high glyphs, bit6=g .. bit0=a, indexed by nibble value (entry 15 first).
   localparam logic [15:0][6:0] GLYPHS = {
      7'b1110001, 7'b1111001, 7'b1011110, 7'b1011000,   // F E d c
      7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,   // b A 9 8
      7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,   // 7 6 5 4
      7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111    // 3 2 1 0
   };

   function automatic logic [6:0] seg_off(input bit active_low);
      return active_low ? 7'h7F : 7'h00;
   endfunction

   function automatic logic [6:0] seg_on(input logic [6:0] glyph, input bit active_low);
      return active_low ? ~glyph : glyph;
   endfunction

   function automatic logic dp_level(input logic lit, input bit active_low);
      return lit ^ active_low;
   endfunction

endpackage

// File: rtl/sseg_scan_driver_seg_decode.sv
// Combinational nibble to active-high seven-segment glyph.
module seg_decode
   import sseg_scan_driver_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   assign glyph = GLYPHS[nibble];

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed, double-buffered seven-segment scan driver with blanking,
// decimal points and leading-zero suppression.
module sseg_scan_driver
   import sseg_scan_driver_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int PRESCALE       = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   hex_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic                  lz_en,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            sseg,
   output logic                  dp,
   output logic                  frame_tick
);

   localparam int IW = $clog2(DIGITS);
   localparam int PW = $clog2(PRESCALE);
   localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);
   localparam logic [PW-1:0]     LAST_PRE = PW'(PRESCALE - 1);
   localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

   logic [PW-1:0]            presc;
   logic [IW-1:0]            idx;
   logic                     tick, wrap;
   logic [DIGITS-1:0][3:0]   sh_hex, act_hex;
   logic [DIGITS-1:0]        sh_dp, sh_blank, act_dp, act_blank;
   logic [DIGITS-1:0]        supp;
   logic                     run;
   logic [DIGITS-1:0]        sel;
   logic [6:0]               glyph;
   logic                     cur_dark, cur_dp;

   assign tick = (presc == LAST_PRE);
   assign wrap = tick && (idx == LAST_IDX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc      <= '0;
         idx        <= '0;
         frame_tick <= 1'b0;
      end else begin
         presc      <= tick ? '0 : presc + 1'b1;
         frame_tick <= wrap;
         if (tick) idx <= wrap ? '0 : idx + 1'b1;
      end
   end

   // A load coinciding with the wrap bypasses the shadow so it lands in this frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_hex    <= '0;
         sh_dp     <= '0;
         sh_blank  <= '1;
         act_hex   <= '0;
         act_dp    <= '0;
         act_blank <= '1;
      end else begin
         if (load) begin
            sh_hex   <= hex_in;
            sh_dp    <= dp_in;
            sh_blank <= blank_in;
         end
         if (wrap) begin
            act_hex   <= load ? hex_in   : sh_hex;
            act_dp    <= load ? dp_in    : sh_dp;
            act_blank <= load ? blank_in : sh_blank;
         end
      end
   end

   // Suppression runs from the top digit down and stops at the first digit with content.
   always_comb begin
      supp = '0;
      run  = lz_en;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         run     = run & (act_hex[i] == 4'h0) & ~act_dp[i];
         supp[i] = run;
      end
   end

   seg_decode u_dec (
      .nibble (act_hex[idx]),
      .glyph  (glyph)
   );

   assign sel      = {{(DIGITS-1){1'b0}}, 1'b1} << idx;
   assign cur_dark = act_blank[idx] | supp[idx];
   assign cur_dp   = act_dp[idx] & ~act_blank[idx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an   <= AN_OFF;
         sseg <= seg_off(SEG_ACTIVE_LOW);
         dp   <= dp_level(1'b0, SEG_ACTIVE_LOW);
      end else begin
         an   <= AN_ACTIVE_LOW ? ~sel : sel;
         sseg <= cur_dark ? seg_off(SEG_ACTIVE_LOW) : seg_on(glyph, SEG_ACTIVE_LOW);
         dp   <= dp_level(cur_dp, SEG_ACTIVE_LOW);
      end
   end

endmodule
